// File: rtl/btn_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release pulses,
// optional auto-repeat while held, and a saturating count of aborted transitions.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_press,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_active,
    output logic [7:0] bounce_count
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX < 1) ? 1 : $clog2(RPT_MAX + 1);
    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             btn_press_q, btn_press_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             repeat_active_q, repeat_active_d;
    logic [7:0]       bounce_q, bounce_d;
    logic             btn_sync;
    logic [RPT_W-1:0] rpt_last;

    assign btn_sync = sync2_q;
    assign rpt_last = repeat_active_q ? PERIOD_LAST : DELAY_LAST;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rpt_cnt_d       = rpt_cnt_q;
        btn_press_d     = btn_press_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        repeat_active_d = repeat_active_q;
        bounce_d        = bounce_q;

        case (state_q)
            ST_RELEASED: begin
                if (btn_sync) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = ST_RELEASED;
                    if (bounce_q != 8'hFF) bounce_d = bounce_q + 8'd1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_PRESSED;
                    btn_press_d   = 1'b1;
                    press_pulse_d = 1'b1;
                    rpt_cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!btn_sync) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (REPEAT_EN) begin
                    // The repeat counter only advances on cycles spent firmly held.
                    if (rpt_cnt_q == rpt_last) begin
                        press_pulse_d   = 1'b1;
                        repeat_active_d = 1'b1;
                        rpt_cnt_d       = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = ST_PRESSED;
                    if (bounce_q != 8'hFF) bounce_d = bounce_q + 8'd1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = ST_RELEASED;
                    btn_press_d     = 1'b0;
                    release_pulse_d = 1'b1;
                    repeat_active_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            state_q         <= ST_RELEASED;
            cnt_q           <= '0;
            rpt_cnt_q       <= '0;
            btn_press_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            repeat_active_q <= 1'b0;
            bounce_q        <= 8'd0;
        end else begin
            sync1_q         <= btn_raw;
            sync2_q         <= sync1_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rpt_cnt_q       <= rpt_cnt_d;
            btn_press_q     <= btn_press_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            repeat_active_q <= repeat_active_d;
            bounce_q        <= bounce_d;
        end
    end

    assign btn_press     = btn_press_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign repeat_active = repeat_active_q;
    assign bounce_count  = bounce_q;

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
- Conditions a raw, bouncy, asynchronous push-button into a clean synchronous button interface for counter logic.
- Provides a debounced level (btn_press), a single-cycle press pulse with optional auto-repeat, a release pulse, and a bounce diagnostic counter.
- Sits between the board pin and the counter/LED logic.
- DEBOUNCE_CYCLES stays small for simulation; the board top overrides it, e.g. 250000 at 25 MHz.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a level change; minimum 2.
- REPEAT_DELAY, 0, cycles from the initial press_pulse to the first repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 4, cycles between successive repeat pulses; minimum 1; ignored when REPEAT_DELAY=0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- btn_raw  in  1  raw asynchronous button, 1 = pressed
- btn_press  out  1  debounced level, registered
- press_pulse  out  1  one-cycle pulse on accepted press and on each auto-repeat
- release_pulse  out  1  one-cycle pulse on accepted release
- repeat_active  out  1  high while at least one repeat pulse has fired in the current press
- bounce_count  out  8  saturating count of aborted transitions

Behaviour:
- Reset: sync flops, btn_press, press_pulse, release_pulse, repeat_active and bounce_count are all 0; FSM is RELEASED; both counters are 0. Reset overrides everything.
- Synchronizer: 2 flops; btn_sync = btn_raw delayed 2 edges. The FSM uses only btn_sync.
- Stability counter: width $clog2(DEBOUNCE_CYCLES+1).
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- RELEASED, btn_sync=1: go to PRESS_WAIT with cnt=1.
- PRESS_WAIT, btn_sync=1, cnt<DEBOUNCE_CYCLES-1: cnt++.
- PRESS_WAIT, btn_sync=1, cnt==DEBOUNCE_CYCLES-1: go to PRESSED, btn_press<=1, press_pulse<=1, repeat counter<=0.
- PRESS_WAIT, btn_sync=0: back to RELEASED, bounce_count++ (saturates at 255), no pulse.
- PRESSED, btn_sync=0: go to RELEASE_WAIT with cnt=1.
- RELEASE_WAIT: mirror of PRESS_WAIT. Completing it gives RELEASED, btn_press<=0, release_pulse<=1, repeat_active<=0. Abort gives PRESSED, bounce_count++, no press_pulse, repeat counter keeps its value.
- Press latency: btn_raw stably 1 at edge k gives press_pulse and btn_press rising at edge k+DEBOUNCE_CYCLES+1. Release latency is identical.
- Auto-repeat (REPEAT_DELAY>0):
  - The repeat counter increments only while in PRESSED and is frozen in RELEASE_WAIT.
  - First repeat press_pulse comes exactly REPEAT_DELAY cycles after the initial press_pulse; repeat_active<=1 on that same edge.
  - Further pulses follow every REPEAT_PERIOD cycles while still PRESSED.
- press_pulse and release_pulse are never high in the same cycle. Both are registered and fall the cycle after assertion.
- bounce_count only clears on rst.
- Reset mid-operation, button held: after rst deasserts, the press is re-debounced from scratch. The first non-reset edge r loads sync1; press_pulse rises at edge r+DEBOUNCE_CYCLES+1. No release_pulse is generated by reset.
- Glitches shorter than DEBOUNCE_CYCLES synchronized samples never change btn_press.

Test Plan:
- Reset: hold rst 3 cycles with btn_raw=1 -> all outputs 0 and bounce_count=0 throughout reset.
- Clean press, DEBOUNCE_CYCLES=4, btn_raw 0->1 before edge 10 and held -> press_pulse high only after edge 15 for exactly one cycle; btn_press=1 from edge 15.
- Bounce, DEBOUNCE_CYCLES=4: btn_raw pattern 1,1,0,1 then held high -> no pulse during the bounce; bounce_count=1; press_pulse 5 edges after the final rise (4 stable samples).
- Release, after a clean press: btn_raw->0 before edge 40 -> release_pulse and btn_press=0 at edge 45; press_pulse stays 0.
- Auto-repeat, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, button held: initial press_pulse at edge P, repeats at P+8, P+12, P+16. repeat_active rises at P+8 and clears with release_pulse. A release bounce mid-hold adds no pulse and increments bounce_count.
- Reset mid PRESS_WAIT with btn_raw held: assert rst at cnt=2, release it at edge r-1 -> exactly one press_pulse at edge r+5 (DEBOUNCE_CYCLES=4) and no release_pulse.
